// File: rtl/console_tx_pkg.sv
// console_tx_pkg -- shared definitions for the console transmitter.
//   Register offsets (addr bit), STATUS bit positions, FSM state encoding
//   and the parity helper used by the frame builder.
package console_tx_pkg;

   localparam logic ADDR_TXDATA = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;

   localparam int unsigned ST_EMPTY_BIT = 0;
   localparam int unsigned ST_FULL_BIT  = 1;
   localparam int unsigned ST_BUSY_BIT  = 2;
   localparam int unsigned ST_OVF_BIT   = 4;
   localparam int unsigned ST_COUNT_LSB = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Even parity: XOR of all data bits.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/console_tx_fifo.sv
// console_tx_fifo -- synchronous FIFO holding bytes waiting to be sent.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (empties the FIFO)
//   push_i   : push request; accepted when not full, or when full with a
//              simultaneous pop
//   data_i   : byte to push
//   pop_i    : pop request; ignored when empty
//   data_o   : head byte (valid while !empty_o)
//   full_o   : FIFO holds DEPTH entries
//   empty_o  : FIFO holds no entries
//   count_o  : number of entries held
module console_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still succeeds then.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
   // modulo DEPTH on their own.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/console_tx.sv
// console_tx -- bus-mapped serial console transmitter with TX FIFO.
//   Optional feature macro: CONSOLE_TX_PARITY_EN (even parity bit,
//   11-bit frame); default build sends 10-bit frames.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   sel   : bus access qualifier
//   we    : 1 = write, 0 = read
//   addr  : 0 = TXDATA, 1 = STATUS
//   wdata : write data ([7:0] TXDATA byte, [4] STATUS OVF clear)
//   rdata : read data, combinational from addr
//   tx    : serial line, idle high
//   idle  : FIFO empty and no frame on the line
module console_tx
   import console_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic        addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        idle
);

   localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

`ifdef CONSOLE_TX_PARITY_EN
   localparam tx_state_e AFTER_DATA = ST_PARITY;
`else
   localparam tx_state_e AFTER_DATA = ST_STOP;
`endif

   tx_state_e      state_q;
   logic [15:0]    cnt_q;
   logic [2:0]     bit_q;
   logic [7:0]     shift_q;
   logic           parity_q;
   logic           tx_q;
   logic           idle_q;
   logic           ovf_q, ovf_d;
   logic           line_bit;

   logic           fifo_full, fifo_empty;
   logic [7:0]     fifo_head;
   logic [CW-1:0]  fifo_count;
   logic           push, pop, overflow;
   logic           wr_txdata, wr_status;
   logic           unused_wdata;

   assign unused_wdata = ^wdata[31:8];

   assign wr_txdata = sel && we && (addr == ADDR_TXDATA);
   assign wr_status = sel && we && (addr == ADDR_STATUS);
   assign push      = wr_txdata;
   assign overflow  = wr_txdata && fifo_full && !pop;

   // Pop from IDLE, or at the last clock of STOP for back-to-back frames.
   assign pop = !fifo_empty &&
                ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (cnt_q == '0)));

   console_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push),
      .data_i  (wdata[7:0]),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Overflow takes priority over a clear in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_status && wdata[ST_OVF_BIT]) ovf_d = 1'b0;
      if (overflow)                       ovf_d = 1'b1;
   end

   always_comb begin
      line_bit = 1'b1;
      case (state_q)
         ST_START:  line_bit = 1'b0;
         ST_DATA:   line_bit = shift_q[0];
         ST_PARITY: line_bit = parity_q;
         default:   line_bit = 1'b1;
      endcase
   end

   // tx and idle are registered from the current state, so the line lags
   // the FSM by one clock; every bit still lasts CLK_DIV clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         idle_q   <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         tx_q   <= line_bit;
         idle_q <= (state_q == ST_IDLE) && fifo_empty && !push;
         if (pop) begin
            shift_q  <= fifo_head;
            parity_q <= even_parity(fifo_head);
            cnt_q    <= RELOAD;
            bit_q    <= '0;
            state_q  <= ST_START;
         end else if (state_q != ST_IDLE) begin
            if (cnt_q != '0) begin
               cnt_q <= cnt_q - 16'd1;
            end else begin
               cnt_q <= RELOAD;
               case (state_q)
                  ST_START: state_q <= ST_DATA;
                  ST_DATA: begin
                     if (bit_q == 3'd7) begin
                        state_q <= AFTER_DATA;
                     end else begin
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= {1'b0, shift_q[7:1]};
                     end
                  end
                  ST_PARITY: state_q <= ST_STOP;
                  default:   state_q <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign tx   = tx_q;
   assign idle = idle_q;

   always_comb begin
      rdata = '0;
      if (addr == ADDR_STATUS) begin
         rdata[ST_COUNT_LSB +: 8] = 8'(fifo_count);
         rdata[ST_OVF_BIT]        = ovf_q;
         rdata[ST_BUSY_BIT]       = (state_q != ST_IDLE);
         rdata[ST_FULL_BIT]       = fifo_full;
         rdata[ST_EMPTY_BIT]      = fifo_empty;
      end
   end

endmodule

// File: tb/tb_console_tx.sv
// tb_console_tx -- directed bench for console_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_console_tx;

   logic        clk;
   logic        rst;
   logic        sel;
   logic        we;
   logic        addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        tx;
   logic        idle;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] rd;
   int unsigned lows;

   console_tx #(
      .CLK_DIV    (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .tx    (tx),
      .idle  (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the write edge.
   task automatic bus_write(input logic a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      @(negedge clk);
      sel = 1'b0; we = 1'b0; wdata = '0;
   endtask

   // Combinational read inside the low clock phase; consumes no edge.
   task automatic bus_read(input logic a, output logic [31:0] d);
      sel = 1'b1; we = 1'b0; addr = a;
      #1 d = rdata;
      sel = 1'b0; addr = 1'b0;
   endtask

   // Samples tx on 4 negedges per bit, from frame bit index 'first'.
   task automatic check_frame(input logic [7:0] d, input int unsigned first, input string tag);
      logic [10:0] f;
      int unsigned nb;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef CONSOLE_TX_PARITY_EN
      f[9] = ^d;
      nb   = 11;
`else
      nb   = 10;
`endif
      for (int unsigned b = first; b < nb; b++) begin
         for (int unsigned s = 0; s < 4; s++) begin
            @(negedge clk);
            check($sformatf("%s_bit%0d_s%0d", tag, b, s), {31'b0, tx}, {31'b0, f[b]});
         end
      end
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 1'b0; wdata = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_idle", {31'b0, idle}, 32'd1);
      bus_read(1'b1, rd);
      check("rst_status", rd, 32'h0000_0001);
      bus_read(1'b0, rd);
      check("txdata_read", rd, 32'h0);

      rst = 1'b1;
      @(negedge clk);

      // Single frame 0x55, start bit 2 edges after the push
      bus_write(1'b0, 32'h55);
      @(negedge clk);
      check("pre_start_tx", {31'b0, tx}, 32'd1);
      check("pre_start_idle", {31'b0, idle}, 32'd0);
      check_frame(8'h55, 0, "f55");
      repeat (2) @(negedge clk);
      check("idle_after_55", {31'b0, idle}, 32'd1);
      bus_read(1'b1, rd);
      check("status_after_55", rd, 32'h0000_0001);

      // Back-to-back frames
      bus_write(1'b0, 32'h41);
      bus_write(1'b0, 32'h42);
      check_frame(8'h41, 0, "f41");
      check_frame(8'h42, 0, "f42");
      repeat (2) @(negedge clk);
      check("idle_after_4142", {31'b0, idle}, 32'd1);

      // Overflow: 0x01 popped, 0x02..0x05 fill, 0x06 dropped
      for (int unsigned i = 1; i <= 6; i++) bus_write(1'b0, 32'(i));
      bus_read(1'b1, rd);
      check("status_ovf_full", rd, 32'h0000_0416);
      check_frame(8'h01, 1, "f01");
      check_frame(8'h02, 0, "f02");
      check_frame(8'h03, 0, "f03");
      check_frame(8'h04, 0, "f04");
      check_frame(8'h05, 0, "f05");
      repeat (2) @(negedge clk);
      check("idle_after_ovf", {31'b0, idle}, 32'd1);
      check("no_frame_06", {31'b0, tx}, 32'd1);
      bus_read(1'b1, rd);
      check("ovf_sticky", rd, 32'h0000_0011);
      bus_write(1'b1, 32'h0000_0010);
      bus_read(1'b1, rd);
      check("ovf_cleared", rd, 32'h0000_0001);

      // Parity patterns (odd and even number of ones)
      bus_write(1'b0, 32'h07);
      bus_write(1'b0, 32'h03);
      check_frame(8'h07, 0, "f07");
      check_frame(8'h03, 0, "f03p");
      repeat (2) @(negedge clk);
      check("idle_after_0703", {31'b0, idle}, 32'd1);

      // Reset during data bit 3, with a second byte queued
      bus_write(1'b0, 32'h55);
      bus_write(1'b0, 32'h66);
      repeat (18) @(negedge clk);
      check("mid_bit3_tx", {31'b0, tx}, 32'd0);
      rst = 1'b0;
      #1;
      check("abort_tx", {31'b0, tx}, 32'd1);
      check("abort_idle", {31'b0, idle}, 32'd1);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = 1'b0; wdata = 32'h77;
      repeat (2) @(negedge clk);
      sel = 1'b0; we = 1'b0; wdata = '0;
      rst = 1'b1;
      bus_read(1'b1, rd);
      check("status_after_abort", rd, 32'h0000_0001);
      lows = 0;
      for (int unsigned i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("no_frame_after_rst", 32'(lows), 32'd0);
      check("idle_after_rst", {31'b0, idle}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/console_tx.md
CONSOLE_TX -- requirements
Module: console_tx

Interface
REQ-001 Parameter CLK_DIV, default 434, SHALL set the clocks per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the TX FIFO entries; power of two, 2..64.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 sel  in  1  SHALL qualify a bus access this cycle.
REQ-006 we  in  1  SHALL mark a write (1) or read (0) when sel=1.
REQ-007 addr  in  1  SHALL select the register: 0 = TXDATA, 1 = STATUS.
REQ-008 wdata  in  32  SHALL carry write data; only [7:0] used for TXDATA, only [4] for STATUS.
REQ-009 rdata  out  32  SHALL return read data combinationally from addr.
REQ-010 tx  out  1  SHALL be the serial line, idle high.
REQ-011 idle  out  1  SHALL be high when the FIFO is empty and no frame is in flight.

Function
REQ-012 A TXDATA write with the FIFO not full SHALL push wdata[7:0].
REQ-013 A TXDATA write with the FIFO full SHALL be dropped and SHALL set the sticky OVF flag, unless a pop occurs the same cycle, in which case the push SHALL be accepted.
REQ-014 A TXDATA read SHALL return 0.
REQ-015 A STATUS read SHALL return {count in [15:8], OVF [4], busy [2], full [1], empty [0]}; all other bits 0.
REQ-016 A STATUS write with wdata[4]=1 SHALL clear OVF; an overflow in the same cycle SHALL win.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into a shift register and enter START on that edge; there is no same-cycle FIFO bypass.
REQ-019 tx SHALL go low exactly 2 rising edges after the edge that accepted the push into an empty FIFO in IDLE.
REQ-020 Each bit SHALL last exactly CLK_DIV clocks, timed by a down-counter reloaded to CLK_DIV-1 at each bit boundary.
REQ-021 The frame SHALL be: start 0, 8 data bits LSB first, optional parity (REQ-027), and stop 1.
REQ-022 In STOP, at its last clock, the FSM SHALL pop again if the FIFO is non-empty and enter START, giving back-to-back frames with no idle gap; otherwise it SHALL enter IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 count SHALL stay exact under simultaneous push and pop: it is unchanged when both are accepted.
REQ-025 The read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 While rst=0, the block SHALL hold tx=1, idle=1, FSM=IDLE, FIFO empty, count=0, OVF=0, and bit counters=0; a frame in flight SHALL be aborted immediately; bus accesses SHALL be ignored.

Configuration
REQ-027 With CONSOLE_TX_PARITY_EN defined, an even-parity bit (XOR of the data bits) SHALL be sent in PARITY, 11-bit frame; without it, PARITY SHALL be skipped, 10-bit frame, DATA→STOP.

Structure
REQ-028 A shared package SHALL hold the register offsets, STATUS bit positions, and the FSM state encoding.
REQ-029 The FIFO SHALL be a separate sub-module, console_tx_fifo, with push/pop/full/empty/count ports.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-030 Release reset, write TXDATA=0x55 → tx low 2 edges later; bits 0,1,0,1,0,1,0,1,0,1 each 4 clocks (40 clocks; 44 with parity, parity=0); idle=1 after.
REQ-031 Write 0x41, 0x42 back-to-back → two frames with no high gap between the stop of 0x41 and the start of 0x42.
REQ-032 Six writes with no gap (0x01..0x06) → 0x01 is popped and the FIFO holds 4, the 6th is dropped, and a STATUS read shows OVF=1, full=1; 0x01..0x05 are transmitted.
REQ-033 Write STATUS wdata=0x10 → OVF=0 on the next read; overflow and clear in the same cycle → OVF=1.
REQ-034 Assert rst mid-frame (during data bit 3) → tx=1 at once, STATUS=0x00000001 after release, no further frames.
REQ-035 With parity enabled, write 0x07 → parity bit 1; with 0x03 → parity bit 0.
